// File: rtl/cic_pkg.sv
// Shared CIC definitions: oversampling-select encoding and its mapping to log2(R).
package cic_pkg;

  localparam logic [2:0] OS_NONE = 3'b000;
  localparam logic [2:0] OS_2    = 3'b001;
  localparam logic [2:0] OS_4    = 3'b010;
  localparam logic [2:0] OS_8    = 3'b011;
  localparam logic [2:0] OS_16   = 3'b100;
  localparam logic [2:0] OS_32   = 3'b101;
  localparam logic [2:0] OS_64   = 3'b110;

  localparam int MAX_OS_LOG2 = 6;

  // 3'b111 is unused and treated like OS_NONE (no decimation).
  function automatic logic [2:0] os_to_log2(input logic [2:0] os_sel);
    return (os_sel >= OS_2 && os_sel <= OS_64) ? os_sel : 3'd0;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) stage: y = x - x_prev, delay register advances on strobe only.
module cic_comb_stage #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         strobe,
  input  logic         clear,
  input  logic [W-1:0] x_in,
  output logic [W-1:0] y_out
);

  logic [W-1:0] x_prev;

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_prev <= '0;
    end else if (clear) begin
      x_prev <= '0;
    end else if (strobe) begin
      x_prev <= x_in;
    end
  end

  // Modulo-2^W subtraction; integrator wrap cancels out here.
  assign y_out = x_in - x_prev;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC back end: decimate by 2^os, NSTAGE combs at the low rate, round and rescale by R^NSTAGE,
// saturate to ODW bits. All flops run on the falling edge, matching the integrator chain.
module cic_comb_decimator
  import cic_pkg::*;
#(
  parameter int IDW    = 23,
  parameter int ODW    = 16,
  parameter int NSTAGE = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [2:0]     os_sel,
  input  logic [IDW-1:0] data_in,
  output logic [ODW-1:0] data_out,
  output logic           data_valid,
  output logic           sat_flag
);

  localparam int SHW = 5;
  localparam int PW  = 3;
  localparam logic signed [IDW:0] SAT_HI = (IDW+1)'((64'sd1 <<< (ODW-1)) - 64'sd1);
  localparam logic signed [IDW:0] SAT_LO = ~SAT_HI;

  if (NSTAGE < 1 || NSTAGE > 4) begin : g_bad_nstage
    $error("cic_comb_decimator: NSTAGE must be 1..4");
  end
  if (IDW < ODW + MAX_OS_LOG2 * NSTAGE) begin : g_bad_width
    $error("cic_comb_decimator: IDW too small for ODW + 6*NSTAGE bit growth");
  end

  logic [2:0]            os_q;
  logic                  os_chg;
  logic [2:0]            os_log2;
  logic [SHW-1:0]        shift;
  logic [6:0]            r_m1;
  logic [5:0]            cnt;
  logic                  strobe;
  logic [PW-1:0]         prime;
  logic [IDW-1:0]        comb_x [NSTAGE+1];
  logic signed [IDW:0]   comb_ext;
  logic signed [IDW:0]   rnd;
  logic signed [IDW:0]   rounded;
  logic signed [IDW:0]   scaled;
  logic signed [ODW-1:0] sat_val;
  logic                  clamped;

  assign os_chg  = (os_q != os_sel);
  assign os_log2 = os_to_log2(os_q);
  assign shift   = SHW'(os_log2) * SHW'(NSTAGE);
  assign r_m1    = (7'd1 << os_log2) - 7'd1;
  // A strobe landing on an os change belongs to the old ratio and is dropped.
  assign strobe  = (cnt == r_m1[5:0]) && !os_chg;

  assign comb_x[0] = data_in;

  for (genvar i = 0; i < NSTAGE; i++) begin : g_comb
    cic_comb_stage #(.W(IDW)) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .strobe (strobe),
      .clear  (os_chg),
      .x_in   (comb_x[i]),
      .y_out  (comb_x[i+1])
    );
  end

  assign comb_ext = $signed({comb_x[NSTAGE][IDW-1], comb_x[NSTAGE]});
  assign rnd      = (shift == '0) ? '0 : $signed((IDW+1)'(1) << (shift - SHW'(1)));
  assign rounded  = comb_ext + rnd;
  assign scaled   = rounded >>> shift;

  always_comb begin
    sat_val = scaled[ODW-1:0];
    clamped = 1'b0;
    if (scaled > SAT_HI) begin
      sat_val = SAT_HI[ODW-1:0];
      clamped = 1'b1;
    end else if (scaled < SAT_LO) begin
      sat_val = SAT_LO[ODW-1:0];
      clamped = 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_q       <= OS_NONE;
      cnt        <= '0;
      prime      <= PW'(NSTAGE);
      data_out   <= '0;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      os_q       <= os_sel;
      data_valid <= 1'b0;
      sat_flag   <= 1'b0;
      if (os_chg) begin
        cnt   <= '0;
        prime <= PW'(NSTAGE);
      end else if (strobe) begin
        cnt <= '0;
        // Comb pipeline must fill before its output means anything.
        if (prime != '0) begin
          prime <= prime - PW'(1);
        end else begin
          data_out   <= sat_val;
          data_valid <= 1'b1;
          sat_flag   <= clamped;
        end
      end else begin
        cnt <= cnt + 6'd1;
      end
    end
  end

endmodule
